// File: rtl/crtc_gen2.sv
// 6845-style CRT controller: ISA register file, raster counters, sync, cursor and light-pen latch.
// Sync/counters advance on divclk; display_enable/cursor optionally skewed 1-2 characters.
module crtc_gen2 #(
    parameter int         H_W       = 8,
    parameter int         V_W       = 7,
    parameter int         RA_W      = 5,
    parameter int         MA_W      = 14,
    parameter logic [7:0] R0_INIT   = 8'd0,
    parameter logic [7:0] R1_INIT   = 8'd0,
    parameter logic [7:0] R2_INIT   = 8'd0,
    parameter logic [7:0] R3_INIT   = 8'd0,
    parameter logic [7:0] R4_INIT   = 8'd0,
    parameter logic [7:0] R5_INIT   = 8'd0,
    parameter logic [7:0] R6_INIT   = 8'd0,
    parameter logic [7:0] R7_INIT   = 8'd0,
    parameter logic [7:0] R8_INIT   = 8'd0,
    parameter logic [7:0] R9_INIT   = 8'd0,
    parameter logic [7:0] R10_INIT  = 8'd0,
    parameter logic [7:0] R11_INIT  = 8'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            divclk,
    input  logic            cs,
    input  logic            a0,
    input  logic            write,
    input  logic            read,
    input  logic [7:0]      bus,
    output logic [7:0]      bus_out,
    input  logic            lock,
    input  logic            lpen_strobe,
    output logic            hsync,
    output logic            vsync,
    output logic            display_enable,
    output logic            cursor,
    output logic [MA_W-1:0] mem_addr,
    output logic [RA_W-1:0] row_addr,
    output logic            line_reset,
    output logic            field
);

    logic [4:0]      addr_q;
    logic [H_W-1:0]  r0, r1, r2;
    logic [7:0]      r3;
    logic [V_W-1:0]  r4, r6, r7;
    logic [RA_W-1:0] r5, r9, r10_start, r11;
    logic [1:0]      r10_blink, r8_skew;
    logic            r8_ilace;
    logic [MA_W-1:0] start_addr, cursor_addr, lpen_addr;

    logic [H_W-1:0]  h_count, h_next;
    logic [V_W-1:0]  v_row, v_next;
    logic [RA_W-1:0] ra;
    logic [RA_W:0]   ra_end;
    logic [MA_W-1:0] ma_row;
    logic [4:0]      blink_cnt, hs_cnt, vs_cnt, hs_width, vs_width;
    logic            hdisp, vdisp, h_wrap, last_row, row_done, frame_end;
    logic            de_raw, cur_raw, blink_ok, de_d1, de_d2, cur_d1, cur_d2;
    logic            lp_s1, lp_s2, lp_s3;
    logic [7:0]      sel_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            r0          <= H_W'(R0_INIT);
            r1          <= H_W'(R1_INIT);
            r2          <= H_W'(R2_INIT);
            r3          <= R3_INIT;
            r4          <= V_W'(R4_INIT);
            r5          <= RA_W'(R5_INIT);
            r6          <= V_W'(R6_INIT);
            r7          <= V_W'(R7_INIT);
            r8_ilace    <= R8_INIT[0];
            r8_skew     <= R8_INIT[5:4];
            r9          <= RA_W'(R9_INIT);
            r10_start   <= RA_W'(R10_INIT[4:0]);
            r10_blink   <= R10_INIT[6:5];
            r11         <= RA_W'(R11_INIT);
            start_addr  <= '0;
            cursor_addr <= '0;
            lpen_addr   <= '0;
            lp_s1       <= 1'b0;
            lp_s2       <= 1'b0;
            lp_s3       <= 1'b0;
        end else begin
            lp_s1 <= lpen_strobe;
            lp_s2 <= lp_s1;
            lp_s3 <= lp_s2;
            if (lp_s2 && !lp_s3)
                lpen_addr <= mem_addr;
            if (cs && write) begin
                if (!a0)
                    addr_q <= bus[4:0];
                else if (!(lock && addr_q <= 5'd9)) begin
                    case (addr_q)
                        5'd0:  r0 <= bus[H_W-1:0];
                        5'd1:  r1 <= bus[H_W-1:0];
                        5'd2:  r2 <= bus[H_W-1:0];
                        5'd3:  r3 <= bus;
                        5'd4:  r4 <= bus[V_W-1:0];
                        5'd5:  r5 <= bus[RA_W-1:0];
                        5'd6:  r6 <= bus[V_W-1:0];
                        5'd7:  r7 <= bus[V_W-1:0];
                        5'd8:  begin r8_ilace <= bus[0]; r8_skew <= bus[5:4]; end
                        5'd9:  r9 <= bus[RA_W-1:0];
                        5'd10: begin r10_start <= bus[RA_W-1:0]; r10_blink <= bus[6:5]; end
                        5'd11: r11 <= bus[RA_W-1:0];
                        5'd12: start_addr[MA_W-1:8]  <= bus[MA_W-9:0];
                        5'd13: start_addr[7:0]       <= bus;
                        5'd14: cursor_addr[MA_W-1:8] <= bus[MA_W-9:0];
                        5'd15: cursor_addr[7:0]      <= bus;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        sel_val = 8'h00;
        case (addr_q)
            5'd0:  sel_val = 8'(r0);
            5'd1:  sel_val = 8'(r1);
            5'd2:  sel_val = 8'(r2);
            5'd3:  sel_val = r3;
            5'd4:  sel_val = 8'(r4);
            5'd5:  sel_val = 8'(r5);
            5'd6:  sel_val = 8'(r6);
            5'd7:  sel_val = 8'(r7);
            5'd8:  sel_val = {2'b00, r8_skew, 3'b000, r8_ilace};
            5'd9:  sel_val = 8'(r9);
            5'd10: sel_val = {1'b0, r10_blink, 5'(r10_start)};
            5'd11: sel_val = 8'(r11);
            5'd12: sel_val = 8'(start_addr[MA_W-1:8]);
            5'd13: sel_val = start_addr[7:0];
            5'd14: sel_val = 8'(cursor_addr[MA_W-1:8]);
            5'd15: sel_val = cursor_addr[7:0];
            5'd16: sel_val = 8'(lpen_addr[MA_W-1:8]);
            5'd17: sel_val = lpen_addr[7:0];
            default: sel_val = 8'h00;
        endcase
    end

    assign bus_out = (cs && read) ? sel_val : 8'h00;

    // The last character row is stretched by R5 scanlines, plus one on odd interlace fields.
    assign h_wrap    = (h_count == r0);
    assign h_next    = h_wrap ? '0 : h_count + 1'b1;
    assign last_row  = (v_row == r4);
    assign ra_end    = last_row ? ({1'b0, r9} + {1'b0, r5} + {{RA_W{1'b0}}, r8_ilace & field})
                                : {1'b0, r9};
    assign row_done  = ({1'b0, ra} == ra_end);
    assign frame_end = row_done && last_row;
    assign v_next    = frame_end ? '0 : v_row + 1'b1;
    assign hs_width  = {r3[3:0] == 4'd0, r3[3:0]};
    assign vs_width  = {r3[7:4] == 4'd0, r3[7:4]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_count   <= '0;
            v_row     <= '0;
            ra        <= '0;
            ma_row    <= '0;
            blink_cnt <= '0;
            field     <= 1'b0;
            hdisp     <= 1'b1;
            vdisp     <= 1'b1;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            hs_cnt    <= '0;
            vs_cnt    <= '0;
            de_d1     <= 1'b0;
            de_d2     <= 1'b0;
            cur_d1    <= 1'b0;
            cur_d2    <= 1'b0;
        end else if (divclk) begin
            h_count <= h_next;
            de_d1   <= de_raw;
            de_d2   <= de_d1;
            cur_d1  <= cur_raw;
            cur_d2  <= cur_d1;

            if (h_wrap)
                hdisp <= 1'b1;
            else if (h_next == r1)
                hdisp <= 1'b0;

            if (h_next == r2 && r2 <= r0) begin
                hsync  <= 1'b1;
                hs_cnt <= 5'd1;
            end else if (hsync) begin
                if (hs_cnt == hs_width)
                    hsync <= 1'b0;
                else
                    hs_cnt <= hs_cnt + 1'b1;
            end

            if (h_wrap) begin
                ra <= row_done ? '0 : ra + 1'b1;
                if (row_done) begin
                    v_row <= v_next;
                    if (frame_end) begin
                        vdisp     <= 1'b1;
                        field     <= r8_ilace ? ~field : 1'b0;
                        blink_cnt <= blink_cnt + 1'b1;
                    end else if (v_next == r6) begin
                        vdisp <= 1'b0;
                    end
                end

                if (frame_end)
                    ma_row <= '0;
                else if (ra == r9)
                    ma_row <= ma_row + MA_W'(r1);

                if (row_done && v_next == r7 && r7 <= r4) begin
                    vsync  <= 1'b1;
                    vs_cnt <= 5'd1;
                end else if (vsync) begin
                    if (vs_cnt == vs_width)
                        vsync <= 1'b0;
                    else
                        vs_cnt <= vs_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_addr   = start_addr + ma_row + MA_W'(h_count);
    assign row_addr   = ra;
    assign line_reset = h_wrap;
    assign de_raw     = hdisp && vdisp;

    always_comb begin
        blink_ok = 1'b1;
        case (r10_blink)
            2'b00: blink_ok = 1'b1;
            2'b01: blink_ok = 1'b0;
            2'b10: blink_ok = blink_cnt[3];
            2'b11: blink_ok = blink_cnt[4];
            default: blink_ok = 1'b1;
        endcase
    end

    assign cur_raw = (mem_addr == cursor_addr) && (ra >= r10_start) && (ra <= r11)
                     && de_raw && blink_ok;

    // Skew 3 is the 6845 "no output" setting, so the cursor is suppressed along with the display.
    always_comb begin
        display_enable = de_raw;
        cursor         = cur_raw;
        case (r8_skew)
            2'd1: begin display_enable = de_d1; cursor = cur_d1; end
            2'd2: begin display_enable = de_d2; cursor = cur_d2; end
            2'd3: begin display_enable = 1'b0;  cursor = 1'b0;   end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_crtc_gen2.sv
// Directed bench for crtc_gen2: expected values queued at stimulus time and checked against DUT outputs.
module tb_crtc_gen2;

    logic        clk = 1'b0;
    logic        rst_n, divclk, cs, a0, write, read, lock, lpen_strobe;
    logic [7:0]  bus, bus_out;
    logic        hsync, vsync, display_enable, cursor, line_reset, field;
    logic [13:0] mem_addr;
    logic [4:0]  row_addr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    crtc_gen2 #(
        .R0_INIT(8'd9), .R1_INIT(8'd8), .R2_INIT(8'd8), .R3_INIT(8'h12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .divclk(divclk), .cs(cs), .a0(a0), .write(write),
        .read(read), .bus(bus), .bus_out(bus_out), .lock(lock), .lpen_strobe(lpen_strobe),
        .hsync(hsync), .vsync(vsync), .display_enable(display_enable), .cursor(cursor),
        .mem_addr(mem_addr), .row_addr(row_addr), .line_reset(line_reset), .field(field)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       tg;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
        end else begin
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            assert (obs === e)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tg, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] e, input logic [31:0] obs);
        push_exp(tag, e);
        pop_check(obs);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            divclk = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic sel(input logic [4:0] ad);
        divclk = 1'b0; cs = 1'b1; write = 1'b1; a0 = 1'b0; bus = {3'b000, ad};
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic wr(input logic [4:0] ad, input logic [7:0] d);
        sel(ad);
        cs = 1'b1; write = 1'b1; a0 = 1'b1; bus = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; a0 = 1'b0;
    endtask

    task automatic rd(input logic [4:0] ad, output logic [7:0] d);
        sel(ad);
        cs = 1'b1; read = 1'b1; a0 = 1'b1;
        #1 d = bus_out;
        cs = 1'b0; read = 1'b0; a0 = 1'b0;
    endtask

    task automatic wait_field_change(output int n);
        logic start;
        start = field;
        n = 0;
        while (n < 200) begin
            tick(1);
            n++;
            if (field !== start) break;
        end
    endtask

    // Frame of 10 lines x 10 chars: rows 0-2 have 2 scanlines, row 3 has 4.
    function automatic logic de_model(input int c);
        int f, h;
        f = (c / 10) % 10;
        h = c % 10;
        return (h < 8) && (f < 4);
    endfunction

    function automatic logic cur_model(input int c);
        int f, h;
        f = (c / 10) % 10;
        h = c % 10;
        return (f < 2) && (h == 3);
    endfunction

    initial begin
        logic [7:0] rv;
        int         n, f, h;

        rst_n = 1'b0; divclk = 1'b1; cs = 1'b0; a0 = 1'b0; write = 1'b0; read = 1'b0;
        bus = 8'h00; lock = 1'b0; lpen_strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_hsync", 0, hsync);
        chk("rst_vsync", 0, vsync);
        chk("rst_de", 1, display_enable);
        chk("rst_mem_addr", 0, mem_addr);
        chk("rst_row_addr", 0, row_addr);
        chk("rst_field", 0, field);
        cs = 1'b1; read = 1'b1;
        #1 chk("rst_r0_read", 9, bus_out);
        cs = 1'b0; read = 1'b0;

        // Horizontal timing: R0=9 R1=8 R2=8 width 2
        for (int c = 0; c < 30; c++) begin
            h = c % 10;
            chk("h_mem_addr", h, mem_addr);
            chk("h_hsync", (h >= 8), hsync);
            chk("h_de", (h < 8), display_enable);
            chk("h_line_reset", (h == 9), line_reset);
            tick(1);
        end

        // Vertical timing
        wr(3, 8'h32); wr(4, 8'd3); wr(5, 8'd2); wr(6, 8'd2); wr(7, 8'd2); wr(9, 8'd1);
        for (int c = 0; c < 300; c++) begin
            if (c >= 100 && (c % 10) == 0) begin
                f = (c / 10) % 10;
                chk("v_row_addr", (f < 6) ? (f % 2) : (f - 6), row_addr);
                chk("v_ma_row", 8 * (f / 2), mem_addr);
                chk("v_vsync", (f >= 4 && f <= 6), vsync);
                chk("v_de", (f < 4), display_enable);
            end
            tick(1);
        end

        // Interlace sync
        wr(8, 8'h01);
        wait_field_change(n);
        chk("il_even_len", 100, n);
        chk("il_field1", 1, field);
        wait_field_change(n);
        chk("il_odd_len", 110, n);
        chk("il_field0", 0, field);
        wait_field_change(n);
        chk("il_even_len2", 100, n);
        wr(8, 8'h00);
        tick(100);
        chk("noil_field_a", 0, field);
        chk("noil_row_start", 0, row_addr);
        chk("noil_ma_start", 0, mem_addr);
        tick(100);
        chk("noil_field_b", 0, field);

        // Skew
        wr(11, 8'd3); wr(14, 8'h00); wr(15, 8'h03);
        for (int c = 0; c < 100; c++) begin
            chk("skew0_de", de_model(c), display_enable);
            chk("skew0_cursor", cur_model(c), cursor);
            tick(1);
        end
        wr(8, 8'h20);
        for (int c = 0; c < 100; c++) begin
            chk("skew2_de", de_model((c + 98) % 100), display_enable);
            chk("skew2_cursor", cur_model((c + 98) % 100), cursor);
            tick(1);
        end
        wr(8, 8'h30);
        for (int c = 0; c < 100; c++) begin
            chk("skew3_de", 0, display_enable);
            tick(1);
        end

        // Lock and register widths
        lock = 1'b1;
        wr(0, 8'h55);
        wr(12, 8'h55);
        rd(0, rv);
        chk("lock_r0", 9, rv);
        rd(12, rv);
        chk("r12_width", 8'h15, rv);
        lock = 1'b0;

        // Light pen
        wr(12, 8'h01); wr(13, 8'h23);
        chk("lpen_mem_addr", 14'h0123, mem_addr);
        sel(16);
        cs = 1'b1; read = 1'b1; a0 = 1'b1; lpen_strobe = 1'b1;
        @(negedge clk);
        lpen_strobe = 1'b0;
        chk("lpen_r16_clk1", 0, bus_out);
        @(negedge clk);
        chk("lpen_r16_clk2", 0, bus_out);
        @(negedge clk);
        chk("lpen_r16_clk3", 8'h01, bus_out);
        cs = 1'b0; read = 1'b0; a0 = 1'b0;
        rd(17, rv);
        chk("lpen_r17", 8'h23, rv);
        rd(20, rv);
        chk("unused_r20", 0, rv);

        // Reset mid-vsync with a coincident write
        n = 0;
        while (vsync !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("pre_rst_vsync", 1, vsync);
        tick(5);
        sel(1);
        rst_n = 1'b0; divclk = 1'b1; cs = 1'b1; write = 1'b1; a0 = 1'b1; bus = 8'h33;
        @(negedge clk);
        rst_n = 1'b1; divclk = 1'b0; cs = 1'b0; write = 1'b0; a0 = 1'b0;
        chk("rst2_vsync", 0, vsync);
        chk("rst2_hsync", 0, hsync);
        chk("rst2_mem_addr", 0, mem_addr);
        chk("rst2_row_addr", 0, row_addr);
        chk("rst2_de", 1, display_enable);
        cs = 1'b1; read = 1'b1; a0 = 1'b1;
        #1 chk("rst2_addr_r0", 9, bus_out);
        cs = 1'b0; read = 1'b0; a0 = 1'b0;
        rd(1, rv);
        chk("rst2_r1", 8, rv);
        rd(3, rv);
        chk("rst2_r3", 8'h12, rv);
        rd(4, rv);
        chk("rst2_r4", 0, rv);
        rd(8, rv);
        chk("rst2_r8", 0, rv);
        rd(12, rv);
        chk("rst2_r12", 0, rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
